serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq.sv | 133 +++++++++++++
 tb/tb_serial_add_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per cycle through an external 1-bit full adder.
// Latency: done_valid rises WIDTH cycles after the accept edge; one operation in flight at a time.
// Backpressure: start_ready is low while RUN/DONE; DONE holds sum/co stable until done_ready.
//
// Ports: clk, rst (async active-high); start_valid/start_ready + a, b, ci request operands;
//        fa_a/fa_b/fa_ci drive the external full adder, fa_sum/fa_co return its result;
//        done_valid/done_ready + sum, co deliver the result; busy is high while RUN.
// Optional macro SERIAL_ADD_SUB_EN adds input port sub (1 = compute a-b, co=1 means no borrow).
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_co,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic              carry_q,  carry_d;
    logic [WIDTH-1:0]  a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]  b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;

    // Subtraction is a + ~b + 1, so it only changes what is loaded at accept.
    logic sub_op;
`ifdef SERIAL_ADD_SUB_EN
    assign sub_op = sub;
`else
    assign sub_op = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b0;
        fa_a        = 1'b0;
        fa_b        = 1'b0;
        fa_ci       = 1'b0;
        sum         = '0;
        co          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = sub_op ? ~b : b;
                    carry_d  = sub_op ? 1'b1 : ci;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                fa_a     = a_sh_q[0];
                fa_b     = b_sh_q[0];
                fa_ci    = carry_q;
                // LSB-first: after WIDTH shifts the first sum bit lands in bit 0.
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_co;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                sum        = sum_sh_q;
                co         = carry_q;
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Testbench for serial_add_seq with a gate-level full adder on the fa_* ports.
// Expected results come from plain arithmetic and are queued at accept; a monitor checks them.
// done_ready is randomized during the random phase to exercise DONE holding its result.
module tb_serial_add_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ci = 1'b0;
    logic             sub_i = 1'b0;
    logic             fa_a, fa_b, fa_ci, fa_sum, fa_co;
    logic             done_valid;
    logic             done_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd_dr = 1'b0;
    bit seen_done = 1'b0;

    logic [WIDTH:0] exp_q[$];
    int             acc_q[$];

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a          (a),
        .b          (b),
        .ci         (ci),
`ifdef SERIAL_ADD_SUB_EN
        .sub        (sub_i),
`endif
        .fa_a       (fa_a),
        .fa_b       (fa_b),
        .fa_ci      (fa_ci),
        .fa_sum     (fa_sum),
        .fa_co      (fa_co),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .sum        (sum),
        .co         (co),
        .busy       (busy)
    );

    // Gate-level 1-bit full adder
    wire t_x, t_g, t_p;
    xor g_x1 (t_x, fa_a, fa_b);
    xor g_x2 (fa_sum, t_x, fa_ci);
    and g_a1 (t_g, fa_a, fa_b);
    and g_a2 (t_p, t_x, fa_ci);
    or  g_o1 (fa_co, t_g, t_p);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {co, sum} of the whole operation as plain arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                             input logic cv, input logic sv);
        logic [WIDTH:0] r;
        int unsigned ai, bi;
        ai = av;
        bi = bv;
        if (sv) begin
            r[WIDTH-1:0] = WIDTH'(ai - bi);
            r[WIDTH]     = (ai >= bi);
        end else begin
            r = (WIDTH+1)'(ai + bi + cv);
        end
        return r;
    endfunction

    // Present an operation, wait for the accept edge, queue its expected result,
    // then scramble the inputs so late changes would corrupt a non-sampling design.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv);
        int n;
        n = 0;
        start_valid = 1'b1;
        a = av;
        b = bv;
        ci = cv;
        sub_i = sv;
        forever begin
            @(negedge clk);
            if (start_ready) break;
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL accept_timeout actual=no_accept required=accept");
                start_valid = 1'b0;
                return;
            end
        end
        tick();
        exp_q.push_back(model(av, bv, cv, sv));
        acc_q.push_back(cyc);
        start_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        ci = 1'($urandom);
        sub_i = 1'($urandom);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            tick();
            n++;
            if (n > 300) begin
                errors++;
                $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
                exp_q.delete();
                acc_q.delete();
                seen_done = 1'b0;
                return;
            end
        end
    endtask

    // Monitor: protocol invariants every cycle plus result/latency scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("start_ready_state", start_ready, !busy && !done_valid);
            if (!busy) chk("fa_zero_outside_run", {fa_a, fa_b, fa_ci}, 0);
            if (!done_valid) begin
                chk("outputs_zero_no_valid", {co, sum}, 0);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=sum %0h co %0b required=no_result", sum, co);
            end else begin
                if (!seen_done) begin
                    seen_done = 1'b1;
                    if (acc_q.size() != 0) chk("latency", cyc - acc_q.pop_front(), WIDTH);
                end
                chk("result_co_sum", {co, sum}, exp_q[0]);
                if (done_ready) begin
                    void'(exp_q.pop_front());
                    seen_done = 1'b0;
                end
            end
        end
    end

    initial begin
        while (1) begin
            @(posedge clk);
            #1;
            if (rnd_dr) done_ready = 1'($urandom);
        end
    end

    initial begin
        int nbusy;
        logic [WIDTH:0] held;

        // Reset values
        #2;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_done_busy", {done_valid, busy}, 0);
        chk("rst_sum_co", {co, sum}, 0);
        chk("rst_fa", {fa_a, fa_b, fa_ci}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic add with busy width
        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        nbusy = 0;
        for (int i = 0; i < 50; i++) begin
            if (done_valid) break;
            if (busy) nbusy++;
            tick();
        end
        chk("busy_cycles", nbusy, WIDTH);
        chk("basic_sum", {co, sum}, 9'h010);
        wait_empty();

        // Wrap / carry-in
        issue(8'hFF, 8'h00, 1'b1, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_empty();

        // Backpressure with ignored start requests in DONE
        done_ready = 1'b0;
        issue(8'hA5, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (done_valid) break;
            tick();
        end
        held = {co, sum};
        for (int k = 0; k < 3; k++) begin
            start_valid = 1'b1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            ci = 1'($urandom);
            #1;
            chk("bp_start_ready_low", start_ready, 0);
            tick();
        end
        chk("bp_held_stable", {co, sum}, held);
        done_ready = 1'b1;
        issue(8'h33, 8'h44, 1'b0, 1'b0);
        wait_empty();

        // Reset mid-operation at cnt=3
        issue(8'h55, 8'h22, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_done_busy", {done_valid, busy}, 0);
        chk("midrst_start_ready", start_ready, 1);
        chk("midrst_sum_co", {co, sum}, 0);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        seen_done = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        wait_empty();

`ifdef SERIAL_ADD_SUB_EN
        issue(8'h05, 8'h07, 1'b0, 1'b1);
        issue(8'h07, 8'h05, 1'b1, 1'b1);
        wait_empty();
`endif

        // Randomized operations with random consumer backpressure
        rnd_dr = 1'b1;
        for (int i = 0; i < 60; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
`else
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
`endif
        end
        rnd_dr = 1'b0;
        done_ready = 1'b1;
        wait_empty();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
